// File: rtl/stamp_matrix_pkg.sv
// Shared types and constants for the MNA stamping engine.
// Element word layout, FP constants and the FSM encoding.
package stamp_matrix_pkg;

  localparam logic [1:0] TYPE_NONE = 2'b00;
  localparam logic [1:0] TYPE_ISRC = 2'b01;
  localparam logic [1:0] TYPE_RES  = 2'b10;
  localparam logic [1:0] TYPE_RSVD = 2'b11;

  localparam int NODE_A_HI = 31;
  localparam int NODE_A_LO = 27;
  localparam int NODE_B_HI = 26;
  localparam int NODE_B_LO = 22;
  localparam int TYPE_HI   = 21;
  localparam int TYPE_LO   = 20;

  localparam logic [4:0]  NODE_LIMIT = 5'd16;
  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
  localparam logic [31:0] FP_SIGN    = 32'h8000_0000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_DECODE,
    S_READ,
    S_ADD,
    S_WRITE,
    S_NEXT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic        vld;
    logic        rhs;
    logic [7:0]  addr;
    logic [31:0] val;
  } term_t;

  function automatic term_t mk_term(
    input logic        vld,
    input logic        rhs,
    input logic [7:0]  addr,
    input logic [31:0] val
  );
    term_t t;
    t.vld  = vld;
    t.rhs  = rhs;
    t.addr = addr;
    t.val  = val;
    return t;
  endfunction

  // {found, index} of the lowest set mask bit at or above 'from'
  function automatic logic [2:0] next_term(
    input logic [3:0] mask,
    input logic [2:0] from
  );
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) res = {1'b1, 2'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/stamp_term_rmw.sv
// Serial read-modify-write of one stamp term.
// Address held through READ and ADD; one write strobe in WRITE.
module stamp_term_rmw
  import stamp_matrix_pkg::*;
#(
  parameter int ADD_LAT = 7,
  parameter int RAM_LAT = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        go_i,
  input  logic        rhs_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] term_i,
  input  logic [31:0] mat_rd_i,
  input  logic [31:0] rhs_rd_i,
  input  logic [31:0] sum_i,
  output logic [7:0]  addr_o,
  output logic [31:0] wdata_o,
  output logic        mat_wren_o,
  output logic        rhs_wren_o,
  output logic [31:0] add_a_o,
  output logic [31:0] add_b_o,
  output logic        done_o,
  output state_t      state_nxt_o
);

  localparam logic [7:0] RD_CNT  = 8'(RAM_LAT - 1);
  localparam logic [7:0] ADD_CNT = 8'(ADD_LAT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q;
  logic [31:0] term_q;
  logic        rhs_q;
  logic        accept;

  assign accept = go_i &&
    ((state_q == S_IDLE) || (state_q == S_WRITE));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_READ:
        if (cnt_q == 8'd0) begin
          state_d = S_ADD;
          cnt_d   = ADD_CNT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      S_ADD:
        if (cnt_q == 8'd0) state_d = S_WRITE;
        else cnt_d = cnt_q - 8'd1;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      state_d = S_READ;
      cnt_d   = RD_CNT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      term_q  <= '0;
      rhs_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q <= addr_i;
        term_q <= term_i;
        rhs_q  <= rhs_i;
      end
    end
  end

  logic in_add, in_wr;
  assign in_add = (state_q == S_ADD);
  // reset in the write cycle must suppress the strobe at once
  assign in_wr  = (state_q == S_WRITE) && !reset_i;

  assign addr_o      = addr_q;
  assign done_o      = (state_q == S_WRITE);
  assign state_nxt_o = state_d;
  assign wdata_o     = in_wr ? sum_i : FP_ZERO;
  assign mat_wren_o  = in_wr && !rhs_q;
  assign rhs_wren_o  = in_wr && rhs_q;
  assign add_a_o     = !in_add ? FP_ZERO :
                       (rhs_q ? rhs_rd_i : mat_rd_i);
  assign add_b_o     = in_add ? term_q : FP_ZERO;

endmodule

// File: rtl/stamp_matrix.sv
// MNA stamping engine: clears G and I, then accumulates
// resistor and current-source stamps from the element list.
module stamp_matrix
  import stamp_matrix_pkg::*;
#(
  parameter int ADD_LAT = 7,
  parameter int RAM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go_stamp,
  input  logic [4:0]  numElements,
  output logic [4:0]  element_addr,
  input  logic [31:0] element_out,
  output logic [4:0]  float_register_addr,
  input  logic [31:0] float_register_out,
  output logic [7:0]  matrix_addr,
  output logic [31:0] matrix_data,
  output logic        matrix_wren,
  input  logic [31:0] matrix_out,
  output logic [3:0]  rhs_addr,
  output logic [31:0] rhs_data,
  output logic        rhs_wren,
  input  logic [31:0] rhs_out,
  output logic [31:0] adder_data_a,
  output logic [31:0] adder_data_b,
  input  logic [31:0] adder_out,
  output logic        stamp_done,
  output logic        stamp_error,
  output logic [4:0]  max_node
);

  localparam logic [7:0] RD_CNT = 8'(RAM_LAT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  clr_q, clr_d;
  logic [4:0]  elem_q, elem_d;
  logic [1:0]  idx_q, idx_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [4:0]  max_q, max_d;

  logic [4:0]  na, nb;
  logic [3:0]  ai, bi;
  logic [1:0]  ty;
  logic [31:0] g, ng;
  logic        bad;
  term_t       terms [4];
  logic [3:0]  mask;
  logic [2:0]  nt;
  logic        go, in_term;
  term_t       cur;

  logic [7:0]  rmw_addr;
  logic [31:0] rmw_wdata;
  logic        rmw_mwren, rmw_rwren, rmw_done;
  state_t      rmw_nxt;
  logic        unused_bits;

  assign na = element_out[NODE_A_HI:NODE_A_LO];
  assign nb = element_out[NODE_B_HI:NODE_B_LO];
  assign ty = element_out[TYPE_HI:TYPE_LO];
  assign ai = 4'(na - 5'd1);
  assign bi = 4'(nb - 5'd1);
  assign g  = float_register_out;
  assign ng = float_register_out ^ FP_SIGN;
  assign unused_bits = ^element_out[19:0];

  assign bad = (ty == TYPE_NONE) || (ty == TYPE_RSVD) ||
               (na > NODE_LIMIT) || (nb > NODE_LIMIT);

  always_comb begin
    for (int i = 0; i < 4; i++) terms[i] = '0;
    unique case (1'b1)
      (ty == TYPE_RES): begin
        terms[0] = mk_term(na != 0, 1'b0, {ai, ai}, g);
        terms[1] = mk_term(nb != 0, 1'b0, {bi, bi}, g);
        terms[2] = mk_term((na != 0) && (nb != 0),
                           1'b0, {ai, bi}, ng);
        terms[3] = mk_term((na != 0) && (nb != 0),
                           1'b0, {bi, ai}, ng);
      end
      (ty == TYPE_ISRC): begin
        terms[0] = mk_term(na != 0, 1'b1, {4'h0, ai}, ng);
        terms[1] = mk_term(nb != 0, 1'b1, {4'h0, bi}, g);
      end
      default: ;
    endcase
    for (int i = 0; i < 4; i++) mask[i] = terms[i].vld;
  end

  assign in_term = (state_q == S_READ) ||
                   (state_q == S_ADD) ||
                   (state_q == S_WRITE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_d   = clr_q;
    elem_d  = elem_q;
    idx_d   = idx_q;
    done_d  = done_q;
    err_d   = err_q;
    max_d   = max_q;
    nt      = 3'b000;
    unique case (state_q)
      S_IDLE:
        if (go_stamp) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          max_d   = '0;
          clr_d   = '0;
          state_d = S_CLEAR;
        end
      S_CLEAR:
        if (&clr_q) begin
          state_d = S_FETCH;
          elem_d  = '0;
          cnt_d   = RD_CNT;
        end else begin
          clr_d = clr_q + 8'd1;
        end
      S_FETCH:
        if (elem_q == numElements) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (cnt_q == 8'd0) begin
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      S_DECODE: begin
        state_d = S_NEXT;
        if (bad) begin
          err_d = 1'b1;
        end else if (na != nb) begin
          if (na > max_d) max_d = na;
          if (nb > max_d) max_d = nb;
          nt = next_term(mask, 3'd0);
        end
      end
      S_READ, S_ADD, S_WRITE:
        if (rmw_done)
          nt = next_term(mask, {1'b0, idx_q} + 3'd1);
      S_NEXT: begin
        elem_d  = elem_q + 5'd1;
        cnt_d   = RD_CNT;
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
    go = nt[2];
    if (go) idx_d = nt[1:0];
    // term phases track the sub-module's own sequencer
    if (in_term || go)
      state_d = (rmw_nxt == S_IDLE) ? S_NEXT : rmw_nxt;
  end

  assign cur = terms[nt[1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      clr_q   <= '0;
      elem_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
      elem_q  <= elem_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
      max_q   <= max_d;
    end
  end

  stamp_term_rmw #(
    .ADD_LAT (ADD_LAT),
    .RAM_LAT (RAM_LAT)
  ) u_rmw (
    .clk_i       (clk),
    .reset_i     (reset),
    .go_i        (go),
    .rhs_i       (cur.rhs),
    .addr_i      (cur.addr),
    .term_i      (cur.val),
    .mat_rd_i    (matrix_out),
    .rhs_rd_i    (rhs_out),
    .sum_i       (adder_out),
    .addr_o      (rmw_addr),
    .wdata_o     (rmw_wdata),
    .mat_wren_o  (rmw_mwren),
    .rhs_wren_o  (rmw_rwren),
    .add_a_o     (adder_data_a),
    .add_b_o     (adder_data_b),
    .done_o      (rmw_done),
    .state_nxt_o (rmw_nxt)
  );

  logic clearing;
  assign clearing = (state_q == S_CLEAR);

  assign element_addr        = elem_q;
  assign float_register_addr = elem_q;
  assign matrix_addr = clearing ? clr_q : rmw_addr;
  assign rhs_addr    = clearing ? clr_q[3:0] : rmw_addr[3:0];
  assign matrix_data = clearing ? FP_ZERO : rmw_wdata;
  assign rhs_data    = clearing ? FP_ZERO : rmw_wdata;
  assign matrix_wren = clearing ? !reset : rmw_mwren;
  assign rhs_wren    = clearing ? (!reset && (clr_q[7:4] == 4'h0))
                                : rmw_rwren;
  assign stamp_done  = done_q;
  assign stamp_error = err_q;
  assign max_node    = max_q;

endmodule
